// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, keeps at most one imem request in
// flight, and hands fetched words to the decoder. It also handles redirects and fetch faults.
//
// Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready
// are both high. An instruction transfers on a cycle where instr_valid && instr_ready
// are both high. Valid signals never depend combinationally on the matching ready.
// A valid that has been raised stays high, with stable payload, until it transfers
// or a redirect withdraws it.
module fetch_sequencer #(
  parameter int unsigned             ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              instr_valid,
  output logic [31:0]       instr_word,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W-1:0] fault_pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_BUS  = 2'b01;
  localparam logic [1:0] FC_MIS  = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              discard_q, discard_d;
  logic [31:0]       instr_word_q, instr_word_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic redirect_ok;
  logic redirect_bad;
  logic accept;
  logic take_misaligned;

  assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign accept       = (state_q == S_REQ) && imem_req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_START;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      instr_word_q  <= '0;
      instr_pc_q    <= '0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      instr_word_q  <= instr_word_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    discard_d       = discard_q;
    instr_word_d    = instr_word_q;
    instr_pc_d      = instr_pc_q;
    fault_d         = fault_q;
    fault_code_d    = fault_code_q;
    fault_pc_d      = fault_pc_q;
    fetch_count_d   = fetch_count_q;
    take_misaligned = 1'b0;

    case (state_q)
      S_START: begin
        state_d = S_REQ;
        if (redirect_bad) take_misaligned = 1'b1;
        else if (redirect_ok) pc_d = redirect_pc;
      end

      S_REQ: begin
        if (accept) begin
          state_d = S_WAIT;
          // The address already went out, so its response must be swallowed.
          if (redirect_valid) discard_d = 1'b1;
        end
        if (redirect_bad) take_misaligned = 1'b1;
        else if (redirect_ok) pc_d = redirect_pc;
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          discard_d = 1'b0;
          if (redirect_bad) begin
            take_misaligned = 1'b1;
          end else if (redirect_ok) begin
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end else if (discard_q) begin
            state_d = S_REQ;
          end else if (imem_rsp_err) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_code_d = FC_BUS;
            fault_pc_d   = pc_q;
          end else begin
            instr_word_d = imem_rsp_data;
            instr_pc_d   = pc_q;
            state_d      = S_HOLD;
          end
        end else if (redirect_bad) begin
          discard_d       = 1'b1;
          take_misaligned = 1'b1;
        end else if (redirect_ok) begin
          discard_d = 1'b1;
          pc_d      = redirect_pc;
        end
      end

      S_HOLD: begin
        if (instr_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          pc_d          = pc_q + ADDR_W'(4);
          state_d       = S_REQ;
        end
        if (redirect_bad) begin
          take_misaligned = 1'b1;
        end else if (redirect_ok) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end
      end

      S_FAULT: begin
        // A request accepted just before a misaligned redirect is still drained here.
        if (discard_q && imem_rsp_valid) discard_d = 1'b0;
        if (redirect_bad) begin
          take_misaligned = 1'b1;
        end else if (redirect_ok) begin
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
          fault_pc_d   = '0;
          pc_d         = redirect_pc;
          if (discard_q && !imem_rsp_valid) begin
            state_d = S_WAIT;
          end else begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_START;
      end
    endcase

    if (take_misaligned) begin
      state_d      = S_FAULT;
      fault_d      = 1'b1;
      fault_code_d = FC_MIS;
      fault_pc_d   = redirect_pc;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == S_HOLD);
  assign instr_word     = instr_word_q;
  assign instr_pc       = instr_pc_q;
  assign fault          = fault_q;
  assign fault_code     = fault_code_q;
  assign fault_pc       = fault_pc_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a directed cycle table, a reset-during-WAIT sequence,
// then randomized traffic checked against a transaction-level reference model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        instr_valid;
  logic [31:0] instr_word;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fault;
  logic [1:0]  fault_code;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  fetch_sequencer #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .instr_valid(instr_valid), .instr_word(instr_word), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault), .fault_code(fault_code), .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h0040_6013;
  endfunction

  // ---------------- memory model (one response per accepted request) ----------------
  logic        mem_busy = 1'b0;
  logic [63:0] mem_addr = '0;
  int          mem_cnt  = 0;
  logic        acc_now  = 1'b0;
  logic [63:0] acc_addr = '0;
  int          acc_lat  = 0;
  int          lat_sel  = 0;
  logic        rst_seen = 1'b0;

  // Called at the sampling point of each cycle.
  task automatic note_accept();
    rst_seen = rst_n;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      chk("one_outstanding", {63'd0, mem_busy}, 64'd0);
      acc_now  = 1'b1;
      acc_addr = imem_req_addr;
      acc_lat  = lat_sel;
    end
  endtask

  // Called just after each rising edge.
  task automatic mem_tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    if (!rst_seen) begin
      mem_busy = 1'b0;
    end else begin
      if (acc_now) begin
        mem_busy = 1'b1;
        mem_addr = acc_addr;
        mem_cnt  = acc_lat;
      end
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = word_of(mem_addr);
          mem_busy       = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
    end
    acc_now = 1'b0;
  endtask

  task automatic end_cycle();
    note_accept();
    @(posedge clk); #1;
    mem_tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; redirect_pc = '0;
    repeat (2) begin
      @(negedge clk);
      end_cycle();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rdy; logic redir; logic [63:0] rpc; logic err; int lat;
    logic        e_rv; logic [63:0] e_ra; logic e_iv; logic [63:0] e_ipc;
    logic        e_f; logic [1:0] e_fc; logic [63:0] e_fpc; logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rdy, input logic redir, input logic [63:0] rpc, input logic err,
                     input int lat, input logic e_rv, input logic [63:0] e_ra, input logic e_iv,
                     input logic [63:0] e_ipc, input logic e_f, input logic [1:0] e_fc,
                     input logic [63:0] e_fpc, input logic [31:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.err = err; v.lat = lat;
    v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_ipc = e_ipc;
    v.e_f = e_f; v.e_fc = e_fc; v.e_fpc = e_fpc; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  // ---------------- reference model state ----------------
  logic [63:0] m_exp_pc;
  logic [31:0] m_count;
  logic        m_faulted;
  logic [1:0]  m_code;
  logic [63:0] m_fpc;
  logic        m_stale;
  logic [63:0] m_req_addr;
  logic        m_prev_redir;

  // Expected pc is the next program-order address; any redirect makes the in-flight
  // response stale; a non-stale error response faults at the requested address.
  task automatic model_cycle();
    logic [63:0] cur_pc;
    cur_pc = m_exp_pc;
    chk("fetch_count", {32'd0, fetch_count}, {32'd0, m_count});
    chk("fault", {63'd0, fault}, {63'd0, m_faulted});
    chk("fault_code", {62'd0, fault_code}, m_faulted ? {62'd0, m_code} : 64'd0);
    chk("fault_pc", fault_pc, m_faulted ? m_fpc : 64'd0);
    if (m_faulted) begin
      chk("req_in_fault", {63'd0, imem_req_valid}, 64'd0);
      chk("iv_in_fault", {63'd0, instr_valid}, 64'd0);
    end
    if (m_prev_redir) chk("iv_after_redirect", {63'd0, instr_valid}, 64'd0);
    if (imem_req_valid) chk("req_addr", imem_req_addr, cur_pc);
    if (instr_valid) begin
      chk("instr_pc", instr_pc, cur_pc);
      chk("instr_word", {32'd0, instr_word}, {32'd0, word_of(cur_pc)});
    end

    if (instr_valid && instr_ready) begin
      m_count  = m_count + 32'd1;
      m_exp_pc = cur_pc + 64'd4;
    end
    if (imem_rsp_valid) begin
      if (!(m_stale || redirect_valid) && imem_rsp_err) begin
        m_faulted = 1'b1; m_code = 2'b01; m_fpc = m_req_addr;
      end
      m_stale = 1'b0;
    end
    if (imem_req_valid && imem_req_ready) begin
      m_stale    = redirect_valid;
      m_req_addr = cur_pc;
    end else if (redirect_valid) begin
      m_stale = 1'b1;
    end
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        m_faulted = 1'b1; m_code = 2'b10; m_fpc = redirect_pc;
      end else begin
        m_faulted = 1'b0; m_code = 2'b00; m_fpc = '0;
        m_exp_pc  = redirect_pc;
      end
    end
    m_prev_redir = redirect_valid;
  endtask

  // ---------------- test ----------------
  initial begin
    logic        seen;
    logic [63:0] rp;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    imem_rsp_err = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    //   rdy redir rpc        err lat | rv ra         iv ipc        f fc fpc        cnt
    add(0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   0); // c0 START
    add(0, 0, 64'h0,   0, 0,  1, 64'h0,   0, 64'h0,   0, 0, 64'h0,   0); // c1 REQ 0x0
    add(0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   0);
    add(1, 0, 64'h0,   0, 0,  0, 64'h0,   1, 64'h0,   0, 0, 64'h0,   0); // c3 deliver 0x0
    add(0, 0, 64'h0,   0, 0,  1, 64'h4,   0, 64'h0,   0, 0, 64'h0,   1);
    add(0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   1);
    for (int k = 0; k < 5; k++)                                          // c6..c10 stall
      add(0, 0, 64'h0, 0, 0,  0, 64'h0,   1, 64'h4,   0, 0, 64'h0,   1);
    add(1, 0, 64'h0,   0, 0,  0, 64'h0,   1, 64'h4,   0, 0, 64'h0,   1);
    add(0, 0, 64'h0,   0, 0,  1, 64'h8,   0, 64'h0,   0, 0, 64'h0,   2); // c12 REQ 0x8
    add(0, 0, 64'h0,   1, 0,  0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   2); // c13 bus error
    add(0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 64'h0,   1, 1, 64'h8,   2);
    add(0, 1, 64'h200, 0, 0,  0, 64'h0,   0, 64'h0,   1, 1, 64'h8,   2); // c15 redirect 0x200
    add(0, 0, 64'h0,   0, 0,  1, 64'h200, 0, 64'h0,   0, 0, 64'h0,   2);
    add(0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   2);
    add(1, 0, 64'h0,   0, 0,  0, 64'h0,   1, 64'h200, 0, 0, 64'h0,   2);
    add(0, 0, 64'h0,   0, 1,  1, 64'h204, 0, 64'h0,   0, 0, 64'h0,   3); // c19 slow response
    add(0, 1, 64'h100, 0, 0,  0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   3); // c20 redirect in WAIT
    add(0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   3); // c21 stale rsp dropped
    add(0, 0, 64'h0,   0, 0,  1, 64'h100, 0, 64'h0,   0, 0, 64'h0,   3);
    add(0, 0, 64'h0,   0, 0,  0, 64'h0,   0, 64'h0,   0, 0, 64'h0,   3);
    add(1, 0, 64'h0,   0, 0,  0, 64'h0,   1, 64'h100, 0, 0, 64'h0,   3);
    add(0, 1, 64'h102, 0, 0,  1, 64'h104, 0, 64'h0,   0, 0, 64'h0,   4); // c25 misaligned redirect
    for (int k = 0; k < 3; k++)
      add(0, 0, 64'h0, 0, 0,  0, 64'h0,   0, 64'h0,   1, 2, 64'h102, 4);

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      imem_req_ready = 1'b1;
      instr_ready    = vq[i].rdy;
      redirect_valid = vq[i].redir;
      redirect_pc    = vq[i].rpc;
      lat_sel        = vq[i].lat;
      imem_rsp_err   = vq[i].err & imem_rsp_valid;
      @(negedge clk);
      chk($sformatf("v%0d_req_valid", i), {63'd0, imem_req_valid}, {63'd0, vq[i].e_rv});
      if (vq[i].e_rv || i == 0) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vq[i].e_ra);
      chk($sformatf("v%0d_instr_valid", i), {63'd0, instr_valid}, {63'd0, vq[i].e_iv});
      if (vq[i].e_iv) begin
        chk($sformatf("v%0d_instr_pc", i), instr_pc, vq[i].e_ipc);
        chk($sformatf("v%0d_instr_word", i), {32'd0, instr_word}, {32'd0, word_of(vq[i].e_ipc)});
      end
      if (i == 0) begin
        chk("rst_instr_word", {32'd0, instr_word}, 64'd0);
        chk("rst_instr_pc", instr_pc, 64'd0);
      end
      chk($sformatf("v%0d_fault", i), {63'd0, fault}, {63'd0, vq[i].e_f});
      chk($sformatf("v%0d_fault_code", i), {62'd0, fault_code}, {62'd0, vq[i].e_fc});
      chk($sformatf("v%0d_fault_pc", i), fault_pc, vq[i].e_fpc);
      chk($sformatf("v%0d_fetch_count", i), {32'd0, fetch_count}, {32'd0, vq[i].e_cnt});
      end_cycle();
    end

    // Reset while a slow fetch is in WAIT; a stray response after reset must be ignored.
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'h300; lat_sel = 3;
    @(negedge clk); end_cycle();
    redirect_valid = 1'b0;
    @(negedge clk); end_cycle();
    @(negedge clk); end_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("wait_before_rst_iv", {63'd0, instr_valid}, 64'd0);
    end_cycle();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; imem_rsp_err = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_outputs_zero", {instr_word, 31'd0, fault, fault_code}, 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_fault_pc", fault_pc, 64'd0);
    chk("rst_fetch_count", {32'd0, fetch_count}, 64'd0);
    end_cycle();
    lat_sel = 0;
    @(negedge clk);
    chk("post_rst_req", {63'd0, imem_req_valid}, 64'd1);
    chk("post_rst_addr", imem_req_addr, 64'h0);
    end_cycle();
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        chk("post_rst_pc", instr_pc, 64'h0);
        chk("post_rst_word", {32'd0, instr_word}, {32'd0, word_of(64'h0)});
        chk("post_rst_no_fault", {63'd0, fault}, 64'd0);
      end
      end_cycle();
    end
    if (!seen) chk("post_rst_timeout", 64'd0, 64'd1);

    // Randomized traffic against the reference model.
    do_reset();
    m_exp_pc = 64'h0; m_count = '0; m_faulted = 1'b0; m_code = 2'b00; m_fpc = '0;
    m_stale = 1'b0; m_req_addr = '0; m_prev_redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      lat_sel        = $urandom_range(0, 3);
      imem_rsp_err   = imem_rsp_valid && ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 7))
        0: rp = {32'h0, $urandom} | 64'(($urandom_range(1, 3)));
        1: rp = 64'hFFFF_FFFF_FFFF_FFF8;
        default: rp = {32'h0, $urandom} & ~64'h3;
      endcase
      if ($urandom_range(0, 7) == 1) rp = (rp & ~64'h3) | 64'h2;
      redirect_pc = rp;
      @(negedge clk);
      model_cycle();
      end_cycle();
    end
    chk("liveness", {63'd0, (m_count >= 32'd20)}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
